mux_scan_reg: RTL and testbench
===============================

// Module: mux_scan_reg
// PURPOSE
//   Parametrised N-channel, W-bit multiplexer with a registered, valid/ready output stage.
//   Two modes:
//     - DIRECT: samples the channel chosen by sel.
//     - SCAN:   walks channels 0..N_CH-1 automatically, taking DWELL samples per channel.
//   Sits between a bank of parallel status/data lines and a single serial consumer
//   (logger, serializer, debug tap). Replaces fixed 16:1 combinational muxes where
//   timing closure or backpressure is needed.
// PARAMETERS
//   N_CH   16  number of input channels, >=2; need not be a power of 2
//   W      8   bits per channel
//   DWELL  2   samples taken per channel in SCAN mode, >=1
//   SEL_W  $clog2(N_CH) (localparam, derived)  width of sel/out_ch
// PORTS
//   clk        in   1         rising-edge clock
//   rst_n      in   1         asynchronous, active-low reset
//   in         in   N_CH*W    channel k occupies in[k*W +: W]
//   sel        in   SEL_W     channel select, DIRECT mode only
//   mode       in   1         0 = DIRECT, 1 = SCAN
//   sample_en  in   1         request to capture a new sample
//   out_ready  in   1         consumer accepts the current beat
//   out        out  W         captured channel data
//   out_ch     out  SEL_W     channel index of the current beat
//   out_valid  out  1         beat valid
//   out_last   out  1         beat is the final sample of channel N_CH-1 in SCAN
//   sel_err    out  1         beat was captured with sel >= N_CH
// BEHAVIOUR
//   Reset (async, rst_n=0)
//     - All outputs 0; state=DIRECT; ch_ptr=0; dwell_cnt=0.
//     - Takes effect immediately, including mid-transfer and mid-scan. Pending beat is discarded.
//   Load condition
//     - load = sample_en & (~out_valid | out_ready).
//     - Latency: the input sampled on the load edge appears on out the next cycle.
//   Transfer and stall
//     - Transfer = out_valid & out_ready. On transfer without load, out_valid -> 0.
//     - While out_valid & ~out_ready, out/out_ch/out_last/sel_err hold stable;
//       in, sel and mode changes are ignored.
//   State machine
//     - States: DIRECT, SCAN. mode is evaluated only on a load edge.
//     - DIRECT -> SCAN when mode=1 at a load: ch_ptr=0, dwell_cnt=0.
//       That same load captures channel 0 as the first scan sample.
//     - SCAN -> DIRECT when mode=0 at a load: that load is a DIRECT capture of sel.
//       ch_ptr and dwell_cnt are cleared.
//   DIRECT load
//     - sel < N_CH:  out = in[sel], out_ch = sel, sel_err = 0.
//     - sel >= N_CH: out = 0, out_ch = sel, sel_err = 1.
//     - out_last = 0.
//   SCAN load
//     - out = in[ch_ptr], out_ch = ch_ptr, sel_err = 0.
//     - If dwell_cnt == DWELL-1: dwell_cnt = 0; ch_ptr = (ch_ptr == N_CH-1) ? 0 : ch_ptr+1.
//       Otherwise dwell_cnt++.
//     - out_last = 1 iff ch_ptr == N_CH-1 and dwell_cnt == DWELL-1 (values before the update).
//   Other rules
//     - sample_en=0: no capture. ch_ptr and dwell_cnt are frozen; the scan resumes where it stopped.
//     - Simultaneous transfer and load: the new beat replaces the old one with no bubble;
//       out_valid stays 1.
//     - Out-of-range data never aliases to a valid channel.
// TESTING  (N_CH=16, W=8, DWELL=2; channel k driven with k*8'h11 unless stated)
//   1. rst_n=0 asserted mid-scan, asynchronously between clock edges
//      -> all outputs 0 before the next edge.
//      After release with mode=1: first out_ch=0.
//   2. DIRECT, sel=5, sample_en=1, out_ready=1
//      -> next cycle out=8'h55, out_ch=5, out_valid=1, sel_err=0.
//   3. Hold out_ready=0 with out=8'h55, then set sel=9 for 3 cycles
//      -> out stays 8'h55.
//      Raise out_ready -> following cycle out=8'h99, with no gap in out_valid.
//   4. SCAN, out_ready=1, sample_en=1 for 33 cycles
//      -> out_ch = 0,0,1,1,...,15,15,0.
//      out_last=1 only on the second beat of channel 15.
//   5. N_CH=12, DIRECT, sel=13
//      -> out=0, out_ch=13, sel_err=1.
//      sel=11 -> out=8'hBB, sel_err=0.
//   6. SCAN stopped at ch 6 with dwell_cnt=1; drop sample_en for 4 cycles, then resume
//      -> next beat is ch 6, then ch 7.
//      Switch mode=0 with sel=2 -> next beat out_ch=2.
//      Return to mode=1 -> next beat out_ch=0.

Source files
------------

// File: rtl/mux_scan_reg.sv
// ---------------------------------------------------------------------------
// mux_scan_reg
//   N_CH-channel, W-bit multiplexer with a registered valid/ready output
//   stage.  In DIRECT mode it captures the channel picked by sel; in SCAN mode
//   it walks channels 0..N_CH-1 on its own, taking DWELL samples per channel.
//   A new sample is captured only when sample_en is high and the output stage
//   is empty or being drained in the same cycle.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in         packed channel bus, channel k at in[k*W +: W]
//   sel        channel select (DIRECT mode only)
//   mode       0 = DIRECT, 1 = SCAN (looked at only when a sample is loaded)
//   sample_en  request to capture a new sample
//   out_ready  consumer accepts the current beat
//   out        captured channel data
//   out_ch     channel index of the current beat
//   out_valid  beat valid
//   out_last   final sample of the last channel in a scan pass
//   sel_err    beat was captured with an out-of-range sel
// ---------------------------------------------------------------------------
module mux_scan_reg #(
    parameter int  N_CH  = 16,
    parameter int  W     = 8,
    parameter int  DWELL = 2,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH*W-1:0] in,
    input  logic [SEL_W-1:0]  sel,
    input  logic              mode,
    input  logic              sample_en,
    input  logic              out_ready,
    output logic [W-1:0]      out,
    output logic [SEL_W-1:0]  out_ch,
    output logic              out_valid,
    output logic              out_last,
    output logic              sel_err
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [0:0] ST_DIRECT = 1'b0;
    localparam logic [0:0] ST_SCAN   = 1'b1;

    localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(N_CH - 1);
    localparam logic [CNT_W-1:0] LAST_DWELL = CNT_W'(DWELL - 1);

    logic [0:0]       state_q,  state_d;
    logic [SEL_W-1:0] ch_ptr_q, ch_ptr_d;
    logic [CNT_W-1:0] dwell_q,  dwell_d;
    logic [W-1:0]     out_q,    out_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic             valid_q,  valid_d;
    logic             last_q,   last_d;
    logic             err_q,    err_d;

    logic             load;
    logic [SEL_W-1:0] scan_ptr;
    logic [CNT_W-1:0] scan_cnt;

    // Explicit compare-and-select so an index that is not a real channel
    // yields zero instead of aliasing onto some other channel.
    function automatic logic [W-1:0] pick(input logic [N_CH*W-1:0] bus,
                                          input logic [SEL_W-1:0]  idx);
        logic [W-1:0] res;
        res = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (int'(idx) == k) begin
                res = bus[k*W +: W];
            end
        end
        return res;
    endfunction

    // Next-state logic.  A load either fills an empty stage or replaces a beat
    // that is leaving this very cycle, so out_valid never bubbles.  Entering
    // SCAN from DIRECT starts the walk at channel 0, dwell 0, and that same
    // load already captures the first scan sample.
    always_comb begin
        load     = sample_en & (~valid_q | out_ready);
        scan_ptr = (state_q == ST_SCAN) ? ch_ptr_q : '0;
        scan_cnt = (state_q == ST_SCAN) ? dwell_q  : '0;

        state_d  = state_q;
        ch_ptr_d = ch_ptr_q;
        dwell_d  = dwell_q;
        out_d    = out_q;
        out_ch_d = out_ch_q;
        valid_d  = valid_q;
        last_d   = last_q;
        err_d    = err_q;

        if (load) begin
            valid_d = 1'b1;
            if (mode) begin
                state_d  = ST_SCAN;
                out_d    = pick(in, scan_ptr);
                out_ch_d = scan_ptr;
                err_d    = 1'b0;
                last_d   = (scan_ptr == LAST_CH) && (scan_cnt == LAST_DWELL);
                if (scan_cnt == LAST_DWELL) begin
                    dwell_d  = '0;
                    ch_ptr_d = (scan_ptr == LAST_CH) ? '0 : scan_ptr + SEL_W'(1);
                end else begin
                    dwell_d  = scan_cnt + CNT_W'(1);
                    ch_ptr_d = scan_ptr;
                end
            end else begin
                state_d  = ST_DIRECT;
                ch_ptr_d = '0;
                dwell_d  = '0;
                out_ch_d = sel;
                last_d   = 1'b0;
                if (int'(sel) < N_CH) begin
                    out_d = pick(in, sel);
                    err_d = 1'b0;
                end else begin
                    out_d = '0;
                    err_d = 1'b1;
                end
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // State and output registers; reset discards any pending beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_DIRECT;
            ch_ptr_q <= '0;
            dwell_q  <= '0;
            out_q    <= '0;
            out_ch_q <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_ptr_q <= ch_ptr_d;
            dwell_q  <= dwell_d;
            out_q    <= out_d;
            out_ch_q <= out_ch_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            err_q    <= err_d;
        end
    end

    assign out       = out_q;
    assign out_ch    = out_ch_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign sel_err   = err_q;

endmodule

// File: tb/tb_mux_scan_reg.sv
// ---------------------------------------------------------------------------
// tb_mux_scan_reg
//   Directed bench for mux_scan_reg.  Instance A uses the default 16-channel
//   configuration; instance B uses 12 channels to exercise out-of-range sel.
//   Expected beats for A are queued when the stimulus is driven and compared
//   by a monitor whenever A hands a beat to the consumer.
// ---------------------------------------------------------------------------
module tb_mux_scan_reg;

    typedef struct {
        logic [7:0] data;
        logic [3:0] ch;
        logic       last;
        logic       err;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;

    logic [16*8-1:0] inA;
    logic [3:0]      selA;
    logic            modeA, seA, rdyA;
    logic [7:0]      outA;
    logic [3:0]      chA;
    logic            validA, lastA, errA;

    logic [12*8-1:0] inB;
    logic [3:0]      selB;
    logic            modeB, seB, rdyB;
    logic [7:0]      outB;
    logic [3:0]      chB;
    logic            validB, lastB, errB;

    beat_t sb[$];
    beat_t monBeat;
    int    checks = 0;
    int    errors = 0;

    mux_scan_reg #(.N_CH(16), .W(8), .DWELL(2)) dutA (
        .clk(clk), .rst_n(rst_n), .in(inA), .sel(selA), .mode(modeA),
        .sample_en(seA), .out_ready(rdyA), .out(outA), .out_ch(chA),
        .out_valid(validA), .out_last(lastA), .sel_err(errA)
    );

    mux_scan_reg #(.N_CH(12), .W(8), .DWELL(2)) dutB (
        .clk(clk), .rst_n(rst_n), .in(inB), .sel(selB), .mode(modeB),
        .sample_en(seB), .out_ready(rdyB), .out(outB), .out_ch(chB),
        .out_valid(validB), .out_last(lastB), .sel_err(errB)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic se, input logic rdy,
                                 input logic md, input logic [3:0] s);
        seA   = se;
        rdyA  = rdy;
        modeA = md;
        selA  = s;
        @(posedge clk);
        #1;
    endtask

    task automatic expectBeat(input logic [7:0] d, input logic [3:0] c,
                              input logic l, input logic e);
        beat_t b;
        b.data = d;
        b.ch   = c;
        b.last = l;
        b.err  = e;
        sb.push_back(b);
    endtask

    // Scan beat number i (counted from entering SCAN) is channel (i/2)%16;
    // out_last marks the second beat of channel 15.
    task automatic scanStep(input int i);
        logic [3:0] ch;
        logic       last;
        ch   = 4'((i / 2) % 16);
        last = ((i % 32) == 31);
        expectBeat(8'(ch * 17), ch, last, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd0);
        checkOutput("scan_ch", chA, ch);
        checkOutput("scan_last", lastA, last);
    endtask

    // Consumer-side monitor: every beat handed over must match the queue head.
    always @(negedge clk) begin
        if (rst_n && validA && rdyA) begin
            checkOutput("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                monBeat = sb.pop_front();
                checkOutput("mon_data", outA,  monBeat.data);
                checkOutput("mon_ch",   chA,   monBeat.ch);
                checkOutput("mon_last", lastA, monBeat.last);
                checkOutput("mon_err",  errA,  monBeat.err);
            end
        end
    end

    initial begin
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) inA[k*8 +: 8] = 8'(k * 17);
        for (int k = 0; k < 12; k++) inB[k*8 +: 8] = 8'(k * 17);
        seA = 0; rdyA = 0; modeA = 0; selA = 0;
        seB = 0; rdyB = 0; modeB = 0; selB = 0;
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("rst_out",   outA,   0);
        checkOutput("rst_ch",    chA,    0);
        checkOutput("rst_valid", validA, 0);
        checkOutput("rst_last",  lastA,  0);
        checkOutput("rst_err",   errA,   0);
        rst_n = 1'b1;

        // DIRECT capture of channel 5
        expectBeat(8'h55, 4'd5, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd5);
        checkOutput("dir_out",   outA,   8'h55);
        checkOutput("dir_ch",    chA,    5);
        checkOutput("dir_valid", validA, 1);
        checkOutput("dir_err",   errA,   0);

        // Stall: sel changes are ignored while the beat is held
        for (int j = 0; j < 3; j++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 4'd9);
            checkOutput("stall_out",   outA,   8'h55);
            checkOutput("stall_valid", validA, 1);
        end
        expectBeat(8'h99, 4'd9, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd9);
        checkOutput("unstall_out",   outA,   8'h99);
        checkOutput("unstall_valid", validA, 1);

        // Full scan pass plus wrap, then continue to channel 6 first dwell
        for (int i = 0; i <= 44; i++) scanStep(i);

        // Pause the scan; meanwhile exercise the 12-channel instance
        seB = 1; rdyB = 1; modeB = 0; selB = 4'd13;
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd0);
        checkOutput("pause_valid", validA, 0);
        checkOutput("b13_out",   outB,   0);
        checkOutput("b13_ch",    chB,    13);
        checkOutput("b13_err",   errB,   1);
        checkOutput("b13_valid", validB, 1);
        selB = 4'd12;
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd0);
        checkOutput("b12_out", outB, 0);
        checkOutput("b12_err", errB, 1);
        selB = 4'd11;
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd0);
        checkOutput("b11_out", outB, 8'hBB);
        checkOutput("b11_ch",  chB,  11);
        checkOutput("b11_err", errB, 0);
        seB = 0;
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd0);
        checkOutput("pause_valid_end", validA, 0);

        // Resume: second dwell of channel 6, then channel 7
        scanStep(45);
        scanStep(46);

        // Back to DIRECT, then a fresh scan starting at channel 0
        expectBeat(8'h22, 4'd2, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd2);
        checkOutput("redir_ch", chA, 2);
        for (int i = 0; i <= 5; i++) scanStep(i);

        // Hold a beat, then reset asynchronously between edges
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_out",   outA,   0);
        checkOutput("arst_ch",    chA,    0);
        checkOutput("arst_valid", validA, 0);
        checkOutput("arst_last",  lastA,  0);
        checkOutput("arst_err",   errA,   0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        scanStep(0);
        checkOutput("arst_resume_valid", validA, 1);
        scanStep(1);

        // Drain and confirm every expected beat was delivered
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
        checkOutput("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
